// File: rtl/axi_rd_arb_pkg.sv
// Shared definitions for the two-master AXI-Lite read-channel arbiter:
// FSM state encoding, AXI read response codes and reset helpers.
package axi_rd_arb_pkg;

  typedef logic [1:0] state_t;

  // Arbiter FSM states. Kept as plain constants so the encoding is fixed
  // and visible in waveforms of older tool flows.
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;

  // AXI read response codes. The arbiter only forwards these; it never
  // originates a response of its own.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Value of the "last granted" flag after reset. It is loaded with the
  // master that must lose the first tie, so that init_prio wins it.
  function automatic logic reset_last(input int init_prio);
    return (init_prio == 0);
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick. Purely combinational: given the request
// vector and the index of the most recently granted master, it names the
// winner. A lone requester always wins; on a tie the master that was not
// granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Winner selection from the request vector and the round-robin pointer.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave read-channel arbiter. Fetch (m0) and load/store
// (m1) share one slave read port with exactly one transaction in flight.
// A grant is only issued in IDLE; the captured address is replayed to the
// slave in ADDR and the slave's R channel is steered to the granted master
// in DATA. Reset is synchronous and also forces every output low while it
// is asserted, so no handshake can complete during reset.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int INIT_PRIO = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m0_rready,
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  input  logic              m1_rready,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              s_rready
);

  state_t            state_q;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic              grant_q;
  logic              last_q;

  logic [1:0]        req;
  logic [1:0]        rready_m;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              in_idle;
  logic              in_addr;
  logic              in_data;
  logic              take;

  logic [1:0]        arready_m;
  logic [1:0]        sel_m;
  logic [1:0]        rvalid_m;
  logic [DATA_W-1:0] rdata_m [2];
  logic [1:0]        rresp_m [2];

  assign req      = {m1_arvalid, m0_arvalid};
  assign rready_m = {m1_rready, m0_rready};

  rr_arb2 u_rr_arb2 (
    .req       (req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Phase decode; everything is masked while reset is high.
  assign in_idle = !reset && (state_q == ST_IDLE);
  assign in_addr = !reset && (state_q == ST_ADDR);
  assign in_data = !reset && (state_q == ST_DATA);

  // A grant happens only in IDLE, in the same cycle the request is seen.
  assign take = in_idle && gnt_valid;

  // Per-master AR acknowledge and R-channel steering. The non-granted
  // master sees an all-zero R channel.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      localparam logic IDX = (gi == 1);
      assign arready_m[gi] = take && (gnt_idx == IDX);
      assign sel_m[gi]     = in_data && (grant_q == IDX);
      assign rvalid_m[gi]  = sel_m[gi] && s_rvalid;
      assign rdata_m[gi]   = sel_m[gi] ? s_rdata : '0;
      assign rresp_m[gi]   = sel_m[gi] ? s_rresp : RESP_OKAY;
    end
  endgenerate

  assign m0_arready = arready_m[0];
  assign m0_rvalid  = rvalid_m[0];
  assign m0_rdata   = rdata_m[0];
  assign m0_rresp   = rresp_m[0];
  assign m1_arready = arready_m[1];
  assign m1_rvalid  = rvalid_m[1];
  assign m1_rdata   = rdata_m[1];
  assign m1_rresp   = rresp_m[1];

  // Slave side: the address comes straight from the capture register so it
  // is stable for as long as the slave stalls arready.
  assign s_arvalid = in_addr;
  assign s_araddr  = in_addr ? addr_q : '0;
  assign s_rready  = in_data && rready_m[grant_q];

  // Next-state logic: IDLE -> ADDR on grant, ADDR -> DATA on slave AR
  // accept, DATA -> IDLE on the R handshake.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE: if (gnt_valid) state_next = ST_ADDR;
      ST_ADDR: if (s_arready) state_next = ST_DATA;
      ST_DATA: if (s_rvalid && s_rready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, captured address and round-robin bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= reset_last(INIT_PRIO);
    end else begin
      state_q <= state_next;
      if (take) begin
        addr_q  <= gnt_idx ? m1_araddr : m0_araddr;
        grant_q <= gnt_idx;
        last_q  <= gnt_idx;
      end
    end
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master, one-slave AXI4-Lite-style read-channel arbiter.
- Shares the single read port of the timer/memory slave between instruction fetch (m0) and load/store (m1).
- Exactly one outstanding transaction; single-beat reads only (len=0, last implied).
- Sits between the core's fetch/LSU units and the downstream slave-side address decode.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
INIT_PRIO, 0, master that wins the first simultaneous request after reset (0 or 1)

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
m0_arvalid  input  1  fetch read request
m0_araddr  input  ADDR_W  fetch read address
m0_arready  output  1  fetch address accepted
m0_rvalid  output  1  fetch read data valid
m0_rdata  output  DATA_W  fetch read data
m0_rresp  output  2  fetch read response
m0_rready  input  1  fetch ready for data
m1_arvalid  input  1  LSU read request
m1_araddr  input  ADDR_W  LSU read address
m1_arready  output  1  LSU address accepted
m1_rvalid  output  1  LSU read data valid
m1_rdata  output  DATA_W  LSU read data
m1_rresp  output  2  LSU read response
m1_rready  input  1  LSU ready for data
s_arvalid  output  1  slave read request
s_araddr  output  ADDR_W  slave read address (registered)
s_arready  input  1  slave address accepted
s_rvalid  input  1  slave data valid; held until s_rready
s_rdata  input  DATA_W  slave data
s_rresp  input  2  slave response
s_rready  output  1  ready toward slave

Behaviour:
- Reset:
  - State IDLE; all outputs 0.
  - addr_q = 0; grant_q = 0.
  - last_q = ~INIT_PRIO, so INIT_PRIO wins the first tie.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any mX_arvalid: pick winner.
    - Only one requesting: that master wins.
    - Both requesting: the master != last_q wins (round-robin).
  - Same cycle:
    - winner's mX_arready = 1 (combinational); loser's = 0.
    - addr_q <= winner araddr; grant_q <= winner; last_q <= winner.
    - next state = ADDR.
  - No request: stay IDLE; both arready = 0.
- ADDR:
  - s_arvalid = 1; s_araddr = addr_q.
  - On s_arready: next state = DATA.
  - s_arvalid and s_araddr stay stable until accepted.
- DATA:
  - Granted master: mX_rvalid = s_rvalid; mX_rdata = s_rdata; mX_rresp = s_rresp.
  - s_rready = granted master's rready.
  - Non-granted master: rvalid = 0, rdata = 0, rresp = 0.
  - On s_rvalid && s_rready: next state = IDLE.
- Latency:
  - Master AR handshake in cycle N; s_arvalid first high in N+1.
  - Earliest data to master in N+2 (slave arready in N+1, rvalid in N+2).
  - Minimum 3 cycles per transaction.
  - Back-to-back: new grant possible in the cycle after R handshake (IDLE cycle).
- No arready is ever given outside IDLE. A master asserting arvalid during ADDR/DATA waits; it must keep arvalid/araddr stable per AXI rules.
- s_rvalid while in IDLE/ADDR is ignored; s_rready = 0 there.
- A response of any code (OKAY, SLVERR, DECERR) is forwarded unmodified; the arbiter never generates responses.
- Fairness: under continuous requests from both masters, grants alternate m0, m1, m0, …
- Single requester may be granted repeatedly regardless of last_q.
- Reset mid-operation: next cycle is IDLE, outputs 0, in-flight transaction dropped. Masters and slave are reset together.
- rresp is 2 bits: 0 = OKAY, 2 = SLVERR, 3 = DECERR.

Decomposition:
- Shared package axi_rd_arb_pkg:
  - State encoding: ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2.
  - Response constants: RESP_OKAY, RESP_SLVERR, RESP_DECERR.
- One sub-module: rr_arb2. Combinational 2-way round-robin pick from (req[1:0], last) giving (gnt_valid, gnt_idx).
- FSM, address register and response mux stay in the top.

Test Plan:
- Single m0 read of 0x0200_0000 with slave returning 0x0000_1234 OKAY:
  - m0_arready pulses in cycle N; s_arvalid with s_araddr = 0x0200_0000 in N+1.
  - m0_rvalid with rdata = 0x1234 in N+2.
  - m1_rvalid stays 0 throughout.
- m0 and m1 both request in the same cycle right after reset (INIT_PRIO = 0):
  - m0 granted first; m1 granted in the IDLE after m0's R handshake.
  - Then continuous dual requests alternate 1, 0, 1, 0.
- Slave holds s_arready low 4 cycles and s_rvalid low 3 cycles after AR:
  - s_arvalid/s_araddr stable for all 4 cycles.
  - No new arready to either master until the R handshake completes.
- Granted m1 deasserts rready for 2 cycles while s_rvalid = 1:
  - s_rready = 0 for those cycles; data 0xDEAD_BEEF held.
  - Transfer completes on the first cycle with rready = 1.
- Slave returns rresp = 2'b11 for address 0x0A00_0000:
  - m1_rresp = 2'b11 forwarded; FSM returns to IDLE.
- Reset asserted during DATA:
  - Next cycle state IDLE, all outputs 0.
  - After reset, a simultaneous request again grants m0 first.
